// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step sequencer for the cpu pipeline plus regfile debug read-port arbiter.
// Latency: raw PAUSE/STEP edge to state change is 2 sync + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; the debug requester holds request until it is done, and grant follows the state.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 1,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PAUSE,
  input  logic             STEP,
  input  logic             cpuin_regfile_request,
  input  logic [3:0]       cpuin_regfile_ra,
  output logic             cpuout_regfile_grant,
  output logic             rf_dbg_sel,
  output logic [3:0]       rf_dbg_ra,
  output logic             pipe_advance,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W = $clog2(STEP_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] STEP_LOAD = SC_W'(STEP_CYCLES);
  localparam logic [SC_W-1:0] STEP_ONE  = SC_W'(1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_STEP  = 2'd2,
    S_DEBUG = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      pause_sync;
  logic [1:0]      step_sync;
  logic            pause_f;
  logic            step_f;
  logic            step_f_q;
  logic            step_evt;
  logic [DB_W-1:0] pause_db_cnt;
  logic [DB_W-1:0] step_db_cnt;
  logic [SC_W-1:0] step_cnt;

  // Two-flop synchronisers for the raw board inputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pause_sync <= 2'b00;
      step_sync  <= 2'b00;
    end else begin
      pause_sync <= {pause_sync[0], PAUSE};
      step_sync  <= {step_sync[0], STEP};
    end
  end

  // PAUSE debouncer: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pause_f      <= 1'b0;
      pause_db_cnt <= '0;
    end else if (pause_sync[1] != pause_f) begin
      if (pause_db_cnt == DB_LAST) begin
        pause_f      <= pause_sync[1];
        pause_db_cnt <= '0;
      end else begin
        pause_db_cnt <= pause_db_cnt + DB_W'(1);
      end
    end else begin
      pause_db_cnt <= '0;
    end
  end

  // STEP debouncer plus delayed copy for rising-edge detection
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      step_f      <= 1'b0;
      step_f_q    <= 1'b0;
      step_db_cnt <= '0;
    end else begin
      step_f_q <= step_f;
      if (step_sync[1] != step_f) begin
        if (step_db_cnt == DB_LAST) begin
          step_f      <= step_sync[1];
          step_db_cnt <= '0;
        end else begin
          step_db_cnt <= step_db_cnt + DB_W'(1);
        end
      end else begin
        step_db_cnt <= '0;
      end
    end
  end

  assign step_evt = step_f & ~step_f_q;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: HALT prefers resume over step over debug; STEP edges outside HALT are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (pause_f) state_nxt = S_HALT;
      S_HALT: begin
        if (!pause_f)                   state_nxt = S_RUN;
        else if (step_evt)              state_nxt = S_STEP;
        else if (cpuin_regfile_request) state_nxt = S_DEBUG;
      end
      S_STEP:  if (step_cnt == STEP_ONE) state_nxt = S_HALT;
      S_DEBUG: if (!cpuin_regfile_request) state_nxt = S_HALT;
      default: state_nxt = S_RUN;
    endcase
  end

  // Outputs: advance and grant are held low combinationally while reset is asserted
  always_comb begin
    pipe_advance         = RST_N && ((state == S_RUN) || (state == S_STEP));
    cpuout_regfile_grant = RST_N && (state == S_DEBUG);
    rf_dbg_sel           = cpuout_regfile_grant;
    ctrl_state           = state;
  end

  // Remaining advance cycles of the current single step
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      step_cnt <= '0;
    end else if (state == S_HALT && state_nxt == S_STEP) begin
      step_cnt <= STEP_LOAD;
    end else if (state == S_STEP) begin
      step_cnt <= step_cnt - STEP_ONE;
    end
  end

  // Debug address: captured on entry so it is valid with the first granted cycle, then tracked
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rf_dbg_ra <= 4'd0;
    end else if (state == S_DEBUG || state_nxt == S_DEBUG) begin
      rf_dbg_ra <= cpuin_regfile_ra;
    end
  end

  // Advance-cycle counter, free-running modulo 2^CNT_W
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cycle_count <= '0;
    end else if (pipe_advance) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic       pause, step, req;
  logic [3:0] ra;

  logic       gnt_a, sel_a, adv_a;
  logic [3:0] dra_a;
  logic [1:0] st_a;
  logic [15:0] cnt_a;

  logic       gnt_b, sel_b, adv_b;
  logic [3:0] dra_b;
  logic [1:0] st_b;
  logic [3:0] cnt_b;

  logic       gnt_c, sel_c, adv_c;
  logic [3:0] dra_c;
  logic [1:0] st_c;
  logic [3:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(1), .CNT_W(16)) dut_a (
    .CLK(clk), .RST_N(rst_a), .PAUSE(pause), .STEP(step),
    .cpuin_regfile_request(req), .cpuin_regfile_ra(ra),
    .cpuout_regfile_grant(gnt_a), .rf_dbg_sel(sel_a), .rf_dbg_ra(dra_a),
    .pipe_advance(adv_a), .ctrl_state(st_a), .cycle_count(cnt_a)
  );

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(3), .CNT_W(4)) dut_b (
    .CLK(clk), .RST_N(rst_b), .PAUSE(pause), .STEP(step),
    .cpuin_regfile_request(req), .cpuin_regfile_ra(ra),
    .cpuout_regfile_grant(gnt_b), .rf_dbg_sel(sel_b), .rf_dbg_ra(dra_b),
    .pipe_advance(adv_b), .ctrl_state(st_b), .cycle_count(cnt_b)
  );

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(8), .CNT_W(4)) dut_c (
    .CLK(clk), .RST_N(rst_c), .PAUSE(pause), .STEP(step),
    .cpuin_regfile_request(req), .cpuin_regfile_ra(ra),
    .cpuout_regfile_grant(gnt_c), .rf_dbg_sel(sel_c), .rf_dbg_ra(dra_c),
    .pipe_advance(adv_c), .ctrl_state(st_c), .cycle_count(cnt_c)
  );

  // advance n rising edges, then settle 1ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    pause = 1'b0; step = 1'b0; req = 1'b0; ra = 4'd0;

    // ---------------- instance A: DEBOUNCE=4, STEP_CYCLES=1, CNT_W=16
    tick(3);
    chk("a_rst_state", 32'(st_a), 32'd0);
    chk("a_rst_adv", 32'(adv_a), 32'd0);
    chk("a_rst_cnt", 32'(cnt_a), 32'd0);
    chk("a_rst_gnt", 32'(gnt_a), 32'd0);
    chk("a_rst_ra", 32'(dra_a), 32'd0);

    rst_a = 1'b1;
    tick(100);
    chk("a_run_state", 32'(st_a), 32'd0);
    chk("a_run_adv", 32'(adv_a), 32'd1);
    chk("a_run_cnt", 32'(cnt_a), 32'd100);

    // pause: HALT exactly 7 edges after the raw edge
    pause = 1'b1;
    tick(6);
    chk("a_pause_edge6_state", 32'(st_a), 32'd0);
    chk("a_pause_edge6_cnt", 32'(cnt_a), 32'd106);
    tick(1);
    chk("a_pause_edge7_state", 32'(st_a), 32'd1);
    chk("a_pause_edge7_adv", 32'(adv_a), 32'd0);
    chk("a_pause_edge7_cnt", 32'(cnt_a), 32'd107);
    tick(10);
    chk("a_halt_frozen_cnt", 32'(cnt_a), 32'd107);

    // 2-cycle STEP glitch is filtered out
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(20);
    chk("a_glitch_state", 32'(st_a), 32'd1);
    chk("a_glitch_cnt", 32'(cnt_a), 32'd107);

    // STEP held 30 cycles -> exactly one advance
    step = 1'b1;
    tick(7);
    chk("a_step_state", 32'(st_a), 32'd2);
    chk("a_step_adv", 32'(adv_a), 32'd1);
    tick(1);
    chk("a_step_back_halt", 32'(st_a), 32'd1);
    tick(22);
    step = 1'b0;
    tick(10);
    chk("a_step30_cnt", 32'(cnt_a), 32'd108);

    // STEP held 200 cycles -> still one advance
    step = 1'b1;
    tick(200);
    step = 1'b0;
    tick(10);
    chk("a_step200_cnt", 32'(cnt_a), 32'd109);
    chk("a_step200_state", 32'(st_a), 32'd1);

    // debug access from HALT
    req = 1'b1; ra = 4'd5;
    tick(1);
    chk("a_dbg_state", 32'(st_a), 32'd3);
    chk("a_dbg_gnt", 32'(gnt_a), 32'd1);
    chk("a_dbg_sel", 32'(sel_a), 32'd1);
    chk("a_dbg_ra5", 32'(dra_a), 32'd5);
    chk("a_dbg_adv", 32'(adv_a), 32'd0);
    ra = 4'd9;
    tick(1);
    chk("a_dbg_ra9", 32'(dra_a), 32'd9);
    req = 1'b0;
    tick(1);
    chk("a_dbg_exit_state", 32'(st_a), 32'd1);
    chk("a_dbg_exit_gnt", 32'(gnt_a), 32'd0);
    chk("a_dbg_exit_sel", 32'(sel_a), 32'd0);
    chk("a_dbg_cnt", 32'(cnt_a), 32'd109);

    // release pause -> RUN 7 edges later
    pause = 1'b0;
    tick(6);
    chk("a_resume_edge6_state", 32'(st_a), 32'd1);
    tick(1);
    chk("a_resume_state", 32'(st_a), 32'd0);
    chk("a_resume_cnt", 32'(cnt_a), 32'd109);

    // request while running is not granted
    req = 1'b1;
    tick(5);
    chk("a_run_req_gnt", 32'(gnt_a), 32'd0);
    chk("a_run_req_state", 32'(st_a), 32'd0);
    chk("a_run_req_cnt", 32'(cnt_a), 32'd114);

    // pause with request pending: HALT then DEBUG
    pause = 1'b1;
    tick(7);
    chk("a_p2_halt_state", 32'(st_a), 32'd1);
    chk("a_p2_halt_cnt", 32'(cnt_a), 32'd121);
    tick(1);
    chk("a_p2_dbg_state", 32'(st_a), 32'd3);
    chk("a_p2_dbg_gnt", 32'(gnt_a), 32'd1);

    // pause release while in DEBUG is ignored
    pause = 1'b0;
    tick(10);
    chk("a_dbg_hold_state", 32'(st_a), 32'd3);
    chk("a_dbg_hold_gnt", 32'(gnt_a), 32'd1);
    req = 1'b0;
    tick(1);
    chk("a_dbg_to_halt", 32'(st_a), 32'd1);
    tick(1);
    chk("a_halt_to_run", 32'(st_a), 32'd0);
    chk("a_final_cnt", 32'(cnt_a), 32'd121);
    rst_a = 1'b0;

    // ---------------- instance B: STEP_CYCLES=3, CNT_W=4
    pause = 1'b1; step = 1'b0; req = 1'b0;
    tick(2);
    rst_b = 1'b1;
    tick(7);
    chk("b_halt_state", 32'(st_b), 32'd1);
    chk("b_halt_cnt", 32'(cnt_b), 32'd7);
    step = 1'b1;
    tick(9);
    chk("b_step3_mid_state", 32'(st_b), 32'd2);
    tick(1);
    chk("b_step3_done_state", 32'(st_b), 32'd1);
    chk("b_step3_cnt", 32'(cnt_b), 32'd10);
    tick(20);
    step = 1'b0;
    tick(10);
    chk("b_step3_hold_cnt", 32'(cnt_b), 32'd10);
    pause = 1'b0;
    tick(7);
    chk("b_resume_state", 32'(st_b), 32'd0);
    tick(5);
    chk("b_cnt_15", 32'(cnt_b), 32'd15);
    tick(1);
    chk("b_cnt_wrap", 32'(cnt_b), 32'd0);
    rst_b = 1'b0;

    // ---------------- instance C: STEP_CYCLES=8, reset mid-step
    pause = 1'b1; step = 1'b0;
    tick(2);
    rst_c = 1'b1;
    tick(7);
    chk("c_halt_state", 32'(st_c), 32'd1);
    step = 1'b1;
    tick(7);
    chk("c_step_state", 32'(st_c), 32'd2);
    tick(2);
    chk("c_step3_adv", 32'(adv_c), 32'd1);
    chk("c_step3_cnt", 32'(cnt_c), 32'd9);
    rst_c = 1'b0;
    #1;
    chk("c_rst_adv_immediate", 32'(adv_c), 32'd0);
    chk("c_rst_gnt_immediate", 32'(gnt_c), 32'd0);
    pause = 1'b0; step = 1'b0;
    tick(2);
    chk("c_rst_state", 32'(st_c), 32'd0);
    chk("c_rst_cnt", 32'(cnt_c), 32'd0);
    rst_c = 1'b1;
    #1;
    chk("c_release_adv", 32'(adv_c), 32'd1);
    tick(1);
    chk("c_release_cnt", 32'(cnt_c), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
